dcache_tbus_sched: RTL

- Registered two-requester scheduler that shares the single dcache tbus port between the store queue (SQ) and the load unit (LSU).
- Captures the winning request and issues exactly one tbus_index_valid pulse per transaction.
- Holds ownership until tbus_operation_done, then returns read data and a done pulse to the owner.
- Adds anti-starvation aging for the LSU and redirect kill of in-flight LSU loads.

---
 rtl/dcache_tbus_sched_pkg.sv | 23 ++
 rtl/dcache_tbus_sched_age_pick.sv | 43 ++++
 rtl/dcache_tbus_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dcache_tbus_sched_pkg.sv
// Purpose: shared op-type codes and scheduler state/owner encodings for the dcache tbus scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: TBUS_OPTYPE_W, TBUS_READ, TBUS_WRITE, sched_state_e, sched_owner_e.
package dcache_tbus_sched_pkg;

  localparam int TBUS_OPTYPE_W = 2;
  // Reset drives the op-type output to 0, so both real op codes are nonzero.
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd1;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd2;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2
  } sched_state_e;

  typedef enum logic {
    OWNER_SQ  = 1'b0,
    OWNER_LSU = 1'b1
  } sched_owner_e;

endpackage

// File: rtl/dcache_tbus_sched_age_pick.sv
// Purpose: two-way SQ/LSU priority picker with an LSU starvation counter.
// Latency: readies are combinational from the valids; the counter updates on the accepting edge.
// Backpressure: no ready is granted unless the scheduler is idle and the dcache can take a request.
// Ports: clock, reset_n; sq_valid, lsu_valid, redirect_valid, tbus_index_ready, in_idle in;
//        sq_ready, lsu_ready, starve_cnt out.
module tbus_age_pick #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sq_valid,
  input  logic             lsu_valid,
  input  logic             redirect_valid,
  input  logic             tbus_index_ready,
  input  logic             in_idle,
  output logic             sq_ready,
  output logic             lsu_ready,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lsu_aged;

  // SQ normally has priority; once the LSU has been passed over LIMIT times it wins.
  assign lsu_aged  = (starve_cnt >= LIMIT);
  assign lsu_ready = in_idle & lsu_valid & tbus_index_ready & ~redirect_valid
                   & (~sq_valid | lsu_aged);
  assign sq_ready  = in_idle & sq_valid & tbus_index_ready & ~lsu_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (lsu_ready) begin
      starve_cnt <= '0;
    end else if (sq_ready && lsu_valid && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dcache_tbus_sched.sv
// Purpose: shares the single dcache tbus port between the store queue and the load unit.
// Latency: accept at T -> tbus_index_valid at T+1; dcache done at D -> requester done/data at D+1.
// Backpressure: one transaction in flight; requesters see ready only in IDLE with tbus_index_ready high.
// Ports: clock, reset_n; sq2arb_* (SQ request/response), lsu2arb_* (LSU request/response),
//        redirect_valid (kills in-flight LSU responses), tbus_* (dcache request/response).
module dcache_tbus_sched
  import dcache_tbus_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sq2arb_tbus_index_valid,
  output logic                     sq2arb_tbus_index_ready,
  input  logic [63:0]              sq2arb_tbus_index,
  input  logic [63:0]              sq2arb_tbus_write_data,
  input  logic [63:0]              sq2arb_tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] sq2arb_tbus_operation_type,
  output logic [63:0]              sq2arb_tbus_read_data,
  output logic                     sq2arb_tbus_operation_done,
  input  logic                     lsu2arb_tbus_index_valid,
  output logic                     lsu2arb_tbus_index_ready,
  input  logic [63:0]              lsu2arb_tbus_index,
  output logic [63:0]              lsu2arb_tbus_read_data,
  output logic                     lsu2arb_tbus_operation_done,
  input  logic                     redirect_valid,
  output logic                     tbus_index_valid,
  input  logic                     tbus_index_ready,
  output logic [63:0]              tbus_index,
  output logic [63:0]              tbus_write_data,
  output logic [63:0]              tbus_write_mask,
  output logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
  input  logic [63:0]              tbus_read_data,
  input  logic                     tbus_operation_done
);

  sched_state_e     state;
  sched_owner_e     owner;
  logic             kill;
  logic             in_idle;
  logic             rsp_fire;
  logic             lsu_drop;
  logic [CNT_W-1:0] starve_cnt_unused;  // kept for observability only

  // Readies are combinational; gating with reset_n keeps them low while reset is held.
  assign in_idle = (state == SCHED_IDLE) & reset_n;

  // A response is taken in WAIT, or in ISSUE only together with the request handshake.
  assign rsp_fire = tbus_operation_done &
                    ((state == SCHED_WAIT) | ((state == SCHED_ISSUE) & tbus_index_ready));
  // A redirect arriving in the completion cycle still kills the LSU response.
  assign lsu_drop = (owner == OWNER_LSU) & (kill | redirect_valid);

  tbus_age_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .clock           (clock),
    .reset_n         (reset_n),
    .sq_valid        (sq2arb_tbus_index_valid),
    .lsu_valid       (lsu2arb_tbus_index_valid),
    .redirect_valid  (redirect_valid),
    .tbus_index_ready(tbus_index_ready),
    .in_idle         (in_idle),
    .sq_ready        (sq2arb_tbus_index_ready),
    .lsu_ready       (lsu2arb_tbus_index_ready),
    .starve_cnt      (starve_cnt_unused)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                       <= SCHED_IDLE;
      owner                       <= OWNER_SQ;
      kill                        <= 1'b0;
      tbus_index_valid            <= 1'b0;
      tbus_index                  <= '0;
      tbus_write_data             <= '0;
      tbus_write_mask             <= '0;
      tbus_operation_type         <= '0;
      sq2arb_tbus_read_data       <= '0;
      sq2arb_tbus_operation_done  <= 1'b0;
      lsu2arb_tbus_read_data      <= '0;
      lsu2arb_tbus_operation_done <= 1'b0;
    end else begin
      sq2arb_tbus_operation_done  <= 1'b0;
      lsu2arb_tbus_operation_done <= 1'b0;

      case (state)
        SCHED_IDLE: begin
          if (lsu2arb_tbus_index_ready) begin
            owner               <= OWNER_LSU;
            tbus_index          <= lsu2arb_tbus_index;
            tbus_write_data     <= '0;
            tbus_write_mask     <= '0;
            tbus_operation_type <= TBUS_READ;
            tbus_index_valid    <= 1'b1;
            state               <= SCHED_ISSUE;
          end else if (sq2arb_tbus_index_ready) begin
            owner               <= OWNER_SQ;
            tbus_index          <= sq2arb_tbus_index;
            tbus_write_data     <= sq2arb_tbus_write_data;
            tbus_write_mask     <= sq2arb_tbus_write_mask;
            tbus_operation_type <= sq2arb_tbus_operation_type;
            tbus_index_valid    <= 1'b1;
            state               <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          if (tbus_index_ready) begin
            tbus_index_valid <= 1'b0;
            state            <= rsp_fire ? SCHED_IDLE : SCHED_WAIT;
          end
        end
        SCHED_WAIT: begin
          if (rsp_fire) state <= SCHED_IDLE;
        end
        default: state <= SCHED_IDLE;
      endcase

      // The dcache cannot abort, so a killed LSU load still runs to completion silently.
      if (rsp_fire) begin
        kill <= 1'b0;
      end else if (state != SCHED_IDLE && owner == OWNER_LSU && redirect_valid) begin
        kill <= 1'b1;
      end

      if (rsp_fire) begin
        if (owner == OWNER_SQ) begin
          sq2arb_tbus_read_data      <= tbus_read_data;
          sq2arb_tbus_operation_done <= 1'b1;
        end else if (!lsu_drop) begin
          lsu2arb_tbus_read_data      <= tbus_read_data;
          lsu2arb_tbus_operation_done <= 1'b1;
        end
      end
    end
  end

endmodule
